// File: rtl/execute_flag_writeback_scheduler_pkg.sv
// Shared types and constants for the execute-stage flag writeback scheduler.
// Unit indices are listed in completion priority order, highest first.
package execute_flag_writeback_scheduler_pkg;

  localparam int FLAG_W        = 5;
  localparam int DEFAULT_DEPTH = 4;
  localparam int NUM_UNITS     = 4;

  typedef enum logic [1:0] {
    UNIT_SHIFT = 2'd0,
    UNIT_ADDER = 2'd1,
    UNIT_MUL   = 2'd2,
    UNIT_LOGIC = 2'd3
  } unit_e;

  typedef struct packed {
    logic              alloc;
    logic              done;
    logic [FLAG_W-1:0] flag;
  } flag_entry_t;

endpackage

// File: rtl/execute_flag_result_merge.sv
// Per-entry completion selector: finds which unit (if any) completes this entry
// this cycle and returns its flag, lower unit index winning a tag collision.
module execute_flag_result_merge
  import execute_flag_writeback_scheduler_pkg::*;
#(
  parameter int TAGW = 2
) (
  input  logic [TAGW-1:0]                   entry_idx,
  input  logic [NUM_UNITS-1:0]              valid,
  input  logic [NUM_UNITS-1:0][TAGW-1:0]    tag,
  input  logic [NUM_UNITS-1:0][FLAG_W-1:0]  flag_in,
  output logic                              hit,
  output logic [FLAG_W-1:0]                 flag
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit  = 1'b0;
    flag = '0;
    // Walk lowest priority first so the highest-priority match is written last.
    for (int u = NUM_UNITS - 1; u >= 0; u--) begin
      if (valid[u] && (tag[u] == entry_idx)) begin
        hit  = 1'b1;
        flag = flag_in[u];
      end
    end
  end

endmodule

// File: rtl/execute_flag_writeback_scheduler.sv
// In-order flag writeback: entries are allocated at dispatch, completed out of
// order by four execution units and committed to the flag register one per cycle.
module execute_flag_writeback_scheduler
  import execute_flag_writeback_scheduler_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int TAGW  = $clog2(DEPTH)
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iRESET_SYNC,
  input  logic              iCTRL_HOLD,
  input  logic              iFLUSH,
  input  logic              iDISP_VALID,
  input  logic              iDISP_FLAG_WRITE,
  output logic              oDISP_READY,
  output logic [TAGW-1:0]   oDISP_TAG,
  input  logic              iSHIFT_VALID,
  input  logic [TAGW-1:0]   iSHIFT_TAG,
  input  logic [FLAG_W-1:0] iSHIFT_FLAG,
  input  logic              iADDER_VALID,
  input  logic [TAGW-1:0]   iADDER_TAG,
  input  logic [FLAG_W-1:0] iADDER_FLAG,
  input  logic              iMUL_VALID,
  input  logic [TAGW-1:0]   iMUL_TAG,
  input  logic [FLAG_W-1:0] iMUL_FLAG,
  input  logic              iLOGIC_VALID,
  input  logic [TAGW-1:0]   iLOGIC_TAG,
  input  logic [FLAG_W-1:0] iLOGIC_FLAG,
  output logic              oFLAG_WE,
  output logic [FLAG_W-1:0] oFLAG_DATA,
  output logic              oFLAG_PENDING,
  output logic [TAGW:0]     oCOUNT
);

  logic [TAGW:0]     head, tail;
  flag_entry_t       entries [DEPTH];
  flag_entry_t       head_entry;
  logic [TAGW-1:0]   head_idx, tail_idx;
  logic              empty, full, flush, alloc_en, commit;

  logic [NUM_UNITS-1:0]             cmp_valid;
  logic [NUM_UNITS-1:0][TAGW-1:0]   cmp_tag;
  logic [NUM_UNITS-1:0][FLAG_W-1:0] cmp_flag;
  logic [DEPTH-1:0]                 hit;
  logic [FLAG_W-1:0]                merged [DEPTH];

  always_comb begin
    cmp_valid[UNIT_SHIFT] = iSHIFT_VALID;
    cmp_tag[UNIT_SHIFT]   = iSHIFT_TAG;
    cmp_flag[UNIT_SHIFT]  = iSHIFT_FLAG;
    cmp_valid[UNIT_ADDER] = iADDER_VALID;
    cmp_tag[UNIT_ADDER]   = iADDER_TAG;
    cmp_flag[UNIT_ADDER]  = iADDER_FLAG;
    cmp_valid[UNIT_MUL]   = iMUL_VALID;
    cmp_tag[UNIT_MUL]     = iMUL_TAG;
    cmp_flag[UNIT_MUL]    = iMUL_FLAG;
    cmp_valid[UNIT_LOGIC] = iLOGIC_VALID;
    cmp_tag[UNIT_LOGIC]   = iLOGIC_TAG;
    cmp_flag[UNIT_LOGIC]  = iLOGIC_FLAG;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_merge
    execute_flag_result_merge #(.TAGW(TAGW)) u_merge (
      .entry_idx (TAGW'(g)),
      .valid     (cmp_valid),
      .tag       (cmp_tag),
      .flag_in   (cmp_flag),
      .hit       (hit[g]),
      .flag      (merged[g])
    );
  end

  assign head_idx   = head[TAGW-1:0];
  assign tail_idx   = tail[TAGW-1:0];
  assign head_entry = entries[head_idx];
  assign empty      = (head == tail);
  assign full       = (head_idx == tail_idx) && (head[TAGW] != tail[TAGW]);
  assign flush      = iFLUSH | iRESET_SYNC;

  // Readiness looks only at registered state: a same-cycle commit frees nothing.
  assign oDISP_READY = !full && !iCTRL_HOLD;
  assign oDISP_TAG   = tail_idx;
  assign alloc_en    = iDISP_VALID && iDISP_FLAG_WRITE && oDISP_READY && !flush;

  assign commit        = head_entry.alloc && head_entry.done && !iCTRL_HOLD && !flush;
  assign oFLAG_WE      = commit;
  assign oFLAG_DATA    = commit ? head_entry.flag : '0;
  assign oFLAG_PENDING = !empty;
  assign oCOUNT        = tail - head;

  // NOTE: state uses non-blocking assignments; the entry array is a handful of
  // flops with architecturally visible alloc/done bits, so it is reset too.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (alloc_en) tail <= tail + 1'b1;
      if (commit)   head <= head + 1'b1;
      // Later assignments win: completion, then commit free, then fresh allocation.
      for (int i = 0; i < DEPTH; i++) begin
        if (hit[i] && entries[i].alloc) begin
          entries[i].done <= 1'b1;
          entries[i].flag <= merged[i];
        end
        if (commit && (head_idx == TAGW'(i))) begin
          entries[i].alloc <= 1'b0;
          entries[i].done  <= 1'b0;
        end
        if (alloc_en && (tail_idx == TAGW'(i))) begin
          entries[i].alloc <= 1'b1;
          entries[i].done  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_flag_writeback_scheduler.sv
// Directed bench: a per-cycle vector table plus hand-written sequences for
// parallel/conflicting completions and asynchronous reset mid-operation.
module tb_execute_flag_writeback_scheduler;

  localparam int TAGW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            rst_sync, hold, flush, disp_valid, disp_fw;
  logic            shift_v, adder_v, mul_v, logic_v;
  logic [TAGW-1:0] shift_t, adder_t, mul_t, logic_t;
  logic [4:0]      shift_f, adder_f, mul_f, logic_f;
  logic            disp_ready, flag_we, flag_pending;
  logic [TAGW-1:0] disp_tag;
  logic [4:0]      flag_data;
  logic [TAGW:0]   count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  execute_flag_writeback_scheduler #(.DEPTH(4)) dut (
    .iCLOCK           (clk),
    .iRESET           (rst),
    .iRESET_SYNC      (rst_sync),
    .iCTRL_HOLD       (hold),
    .iFLUSH           (flush),
    .iDISP_VALID      (disp_valid),
    .iDISP_FLAG_WRITE (disp_fw),
    .oDISP_READY      (disp_ready),
    .oDISP_TAG        (disp_tag),
    .iSHIFT_VALID     (shift_v),
    .iSHIFT_TAG       (shift_t),
    .iSHIFT_FLAG      (shift_f),
    .iADDER_VALID     (adder_v),
    .iADDER_TAG       (adder_t),
    .iADDER_FLAG      (adder_f),
    .iMUL_VALID       (mul_v),
    .iMUL_TAG         (mul_t),
    .iMUL_FLAG        (mul_f),
    .iLOGIC_VALID     (logic_v),
    .iLOGIC_TAG       (logic_t),
    .iLOGIC_FLAG      (logic_f),
    .oFLAG_WE         (flag_we),
    .oFLAG_DATA       (flag_data),
    .oFLAG_PENDING    (flag_pending),
    .oCOUNT           (count)
  );

  typedef struct {
    logic       dv, fw, hold, flush, rsync;
    logic [1:0] unit;
    logic       cv;
    logic [1:0] ctag;
    logic [4:0] cflag;
    logic       we;
    logic [4:0] data;
    logic       ready;
    logic [1:0] tag;
    logic [2:0] cnt;
    logic       pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic dv, logic fw, logic hd, logic fl, logic rs,
                              logic [1:0] unit, logic cv, logic [1:0] ctag, logic [4:0] cflag,
                              logic we, logic [4:0] data, logic ready, logic [1:0] tag,
                              logic [2:0] cnt, logic pend);
    vec_t v;
    v.dv = dv; v.fw = fw; v.hold = hd; v.flush = fl; v.rsync = rs;
    v.unit = unit; v.cv = cv; v.ctag = ctag; v.cflag = cflag;
    v.we = we; v.data = data; v.ready = ready; v.tag = tag; v.cnt = cnt; v.pend = pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst_sync = 0; hold = 0; flush = 0; disp_valid = 0; disp_fw = 0;
    shift_v = 0; adder_v = 0; mul_v = 0; logic_v = 0;
    shift_t = 0; adder_t = 0; mul_t = 0; logic_t = 0;
    shift_f = 0; adder_f = 0; mul_f = 0; logic_f = 0;
  endtask

  task automatic check_outs(input string tagname, input logic we, input logic [4:0] data,
                            input logic ready, input logic [1:0] tag, input logic [2:0] cnt,
                            input logic pend);
    check({tagname, " we"},      32'(flag_we),      32'(we));
    check({tagname, " data"},    32'(flag_data),    32'(data));
    check({tagname, " ready"},   32'(disp_ready),   32'(ready));
    check({tagname, " tag"},     32'(disp_tag),     32'(tag));
    check({tagname, " count"},   32'(count),        32'(cnt));
    check({tagname, " pending"}, 32'(flag_pending), 32'(pend));
  endtask

  task automatic apply_vec(input vec_t v);
    idle_inputs();
    disp_valid = v.dv; disp_fw = v.fw; hold = v.hold; flush = v.flush; rst_sync = v.rsync;
    case (v.unit)
      2'd0: begin shift_v = v.cv; shift_t = v.ctag; shift_f = v.cflag; end
      2'd1: begin adder_v = v.cv; adder_t = v.ctag; adder_f = v.cflag; end
      2'd2: begin mul_v   = v.cv; mul_t   = v.ctag; mul_f   = v.cflag; end
      default: begin logic_v = v.cv; logic_t = v.ctag; logic_f = v.cflag; end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1;

    //        dv fw hd fl rs  un cv tg flag    we data  rdy tag cnt pend
    // Out-of-order completion: adder finishes tag 1 before mul finishes tag 0.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 5'h03, 0, 5'h00, 1, 2, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 2, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 5'h10, 0, 5'h00, 1, 2, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 1, 5'h10, 1, 2, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 1, 5'h03, 1, 2, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 2, 0, 0));
    // Flush to realign pointers, then fill the queue.
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 2, 2, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 3, 3, 1));
    // Full: dispatch refused, commit cycle keeps ready low, then wrap to tag 0.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 5'h05, 0, 5'h00, 0, 0, 4, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 1, 5'h05, 0, 0, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 0, 3, 1));
    // Under hold, complete tags 1 and 2, then flush (over hold) with a logic completion.
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 1, 5'h0A, 0, 5'h00, 0, 0, 3, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 2, 1, 2, 5'h0B, 0, 5'h00, 0, 0, 3, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 3, 1, 3, 5'h0C, 0, 5'h00, 0, 0, 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 0, 0, 0));
    // Flushed done bits must not reappear: entry 1 stays pending after entry 0 commits.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 2, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'h11, 0, 5'h00, 1, 2, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 1, 5'h11, 1, 2, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 2, 1, 1));
    // Synchronous reset behaves like flush.
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0, 5'h00, 1, 2, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 0, 0, 0));
    // Hold: completion captured, commit deferred until hold drops.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 5'h1F, 0, 5'h00, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 1, 5'h1F, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 1, 0, 0));
    // Dispatch without flag write allocates nothing.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 1, 0, 0));
    // Completion to an unallocated entry is dropped.
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 1, 5'h07, 0, 5'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 2, 1, 1));
    // Allocation and commit in the same cycle leave the count unchanged.
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 5'h02, 0, 5'h00, 1, 2, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 1, 5'h02, 1, 2, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 1, 0, 0, 0));

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    #1 check_outs("reset", 0, 5'h00, 1, 0, 0, 0);
    @(negedge clk);
    rst = 0;
    #1 check_outs("post_reset", 0, 5'h00, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      apply_vec(vecs[i]);
      #1 check_outs($sformatf("row%0d", i), vecs[i].we, vecs[i].data, vecs[i].ready,
                    vecs[i].tag, vecs[i].cnt, vecs[i].pend);
    end

    // Parallel completions on distinct tags from shift and logic.
    @(negedge clk); idle_inputs(); disp_valid = 1; disp_fw = 1;
    #1 check("par alloc0 tag", 32'(disp_tag), 32'd0);
    @(negedge clk); idle_inputs(); disp_valid = 1; disp_fw = 1;
    #1 check("par alloc1 tag", 32'(disp_tag), 32'd1);
    @(negedge clk); idle_inputs();
    shift_v = 1; shift_t = 0; shift_f = 5'h01;
    logic_v = 1; logic_t = 1; logic_f = 5'h1E;
    #1 check("par capture we", 32'(flag_we), 32'd0);
    @(negedge clk); idle_inputs();
    #1 check_outs("par commit0", 1, 5'h01, 1, 2, 2, 1);
    @(negedge clk); idle_inputs();
    #1 check_outs("par commit1", 1, 5'h1E, 1, 2, 1, 1);
    @(negedge clk); idle_inputs();
    #1 check_outs("par drained", 0, 5'h00, 1, 2, 0, 0);

    // Adder and multiplier name the same tag: adder wins.
    @(negedge clk); idle_inputs(); flush = 1;
    @(negedge clk); idle_inputs(); disp_valid = 1; disp_fw = 1;
    #1 check("conf alloc tag", 32'(disp_tag), 32'd0);
    @(negedge clk); idle_inputs();
    adder_v = 1; adder_t = 0; adder_f = 5'h05;
    mul_v   = 1; mul_t   = 0; mul_f   = 5'h1A;
    #1 check("conf capture we", 32'(flag_we), 32'd0);
    @(negedge clk); idle_inputs();
    #1 check_outs("conf commit", 1, 5'h05, 1, 1, 1, 1);

    // Asynchronous reset while a commit is being presented.
    @(negedge clk); idle_inputs(); disp_valid = 1; disp_fw = 1;
    #1 check("arst alloc tag", 32'(disp_tag), 32'd1);
    @(negedge clk); idle_inputs(); shift_v = 1; shift_t = 1; shift_f = 5'h15;
    @(negedge clk); idle_inputs();
    #1 check_outs("arst before", 1, 5'h15, 1, 2, 1, 1);
    #1 rst = 1;
    #1 check_outs("arst during", 0, 5'h00, 1, 0, 0, 0);
    @(negedge clk); rst = 0;
    @(negedge clk); idle_inputs();
    #1 check_outs("arst after", 0, 5'h00, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_flag_writeback_scheduler.md
# execute_flag_writeback_scheduler

In-order writeback scheduler for the execute-stage flag register. Each dispatched flag-writing instruction gets a tag. The shift, adder, multiplier and logic units complete out of order, each returning a tag and a 5-bit flag result. The scheduler holds these results in a small circular queue and releases them to the flag register strictly in program order, one per cycle.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- TAGW, $clog2(DEPTH): tag width.

Ports:
- iCLOCK  in  1  clock; all state updates on rising edge.
- iRESET  in  1  reset; asynchronous, active-high.
- iRESET_SYNC  in  1  synchronous clear; identical effect to iFLUSH.
- iCTRL_HOLD  in  1  pipeline hold; stalls allocation and commit.
- iFLUSH  in  1  discard every queued entry.
- iDISP_VALID  in  1  an instruction dispatches this cycle.
- iDISP_FLAG_WRITE  in  1  the dispatching instruction writes flags.
- oDISP_READY  out  1  queue can accept an allocation.
- oDISP_TAG  out  TAGW  tag assigned to the allocation made this cycle.
- iSHIFT_VALID / iSHIFT_TAG / iSHIFT_FLAG  in  1 / TAGW / 5  shift unit completion.
- iADDER_VALID / iADDER_TAG / iADDER_FLAG  in  1 / TAGW / 5  adder completion.
- iMUL_VALID / iMUL_TAG / iMUL_FLAG  in  1 / TAGW / 5  multiplier completion.
- iLOGIC_VALID / iLOGIC_TAG / iLOGIC_FLAG  in  1 / TAGW / 5  logic unit completion.
- oFLAG_WE  out  1  write enable to the flag register.
- oFLAG_DATA  out  5  flag value to write.
- oFLAG_PENDING  out  1  at least one entry is allocated (consumers of flags must wait).
- oCOUNT  out  TAGW+1  number of allocated entries.

## Operation
- State per entry: alloc bit, done bit, flag[4:0].
- Pointers: head and tail, each TAGW+1 bits.
  - Empty: head == tail.
  - Full: the low TAGW bits are equal and the MSBs differ.
- Allocate when iDISP_VALID & iDISP_FLAG_WRITE & oDISP_READY.
  - oDISP_READY = !full & !iCTRL_HOLD. It depends on registered state only; a commit in the same cycle does not free a slot for that cycle.
  - oDISP_TAG = tail[TAGW-1:0].
  - On allocation: entry[tail].alloc = 1, done = 0; tail increments and wraps naturally.
  - A dispatch with iDISP_FLAG_WRITE = 0 allocates nothing.
- Completion: each valid port writes its flag into entry[tag] and sets done.
  - Completions are captured even while iCTRL_HOLD is high.
  - A completion to an entry with alloc = 0 is ignored.
  - Two ports naming the same tag in one cycle is a protocol error. Defined resolution: shift > adder > mul > logic.
  - Distinct tags complete in parallel, up to 4 per cycle.
- Commit: oFLAG_WE = head entry alloc & done & !iCTRL_HOLD & !flush, where flush = iFLUSH | iRESET_SYNC.
  - oFLAG_DATA = head entry flag.
  - On commit: the head entry is freed and head increments.
  - oFLAG_DATA = 5'h00 whenever oFLAG_WE = 0.
- Simultaneous allocation and commit: both take effect; oCOUNT is unchanged.
- Flush (iFLUSH or iRESET_SYNC):
  - All alloc and done bits clear; head = tail = 0.
  - Allocation and completions in the same cycle are discarded.
  - oFLAG_WE = 0 that cycle.
  - Flush overrides iCTRL_HOLD.
- Outputs: oFLAG_PENDING = !empty. oCOUNT = tail - head.

## Timing
- Reset values:
  - Inside the block: all entries cleared, head = tail = 0.
  - Outputs: oFLAG_WE = 0, oFLAG_DATA = 0, oDISP_READY = 1, oDISP_TAG = 0, oFLAG_PENDING = 0, oCOUNT = 0.
- Latency: a completion captured at the edge ending cycle N can produce oFLAG_WE in cycle N+1 if that entry is head. There is no same-cycle bypass.
- oFLAG_WE and oFLAG_DATA are combinational from registered head state. The flag register samples them at the edge ending that cycle.
- Throughput: one commit per cycle; one allocation per cycle.
- Hold: no allocation and no commit. Queue contents are retained apart from completions. Commit resumes in the first cycle after hold deasserts.
- Asynchronous iRESET mid-operation: the queue clears immediately and all outputs go to their reset values.

## Structure
- Shared package:
  - FLAG_W = 5 and the default DEPTH.
  - A flag_entry_t struct with fields alloc, done and flag.
  - An enum of unit indices (SHIFT, ADDER, MUL, LOGIC) in priority order.
- One sub-module, execute_flag_result_merge: combinational, per entry. It takes the four completion ports plus the entry index and returns a hit bit and the selected flag, applying the fixed priority.
- Top level: pointers, entry array, commit and flush logic.

## Test plan
- Reset: assert iRESET for 2 cycles -> oDISP_READY=1, oDISP_TAG=0, oCOUNT=0, oFLAG_WE=0, oFLAG_PENDING=0.
- Out-of-order completion:
  - Stimulus: allocate tags 0 and 1. Cycle 3: ADDER completes tag 1 with 5'h03. Cycle 5: MUL completes tag 0 with 5'h10.
  - Required: oFLAG_WE cycle 6 with data 5'h10, then cycle 7 with data 5'h03; no write before cycle 6.
- Full boundary:
  - Stimulus: 4 allocations (tags 0..3), then complete tag 0.
  - Required: oCOUNT=4 and oDISP_READY=0 during the commit cycle; oDISP_READY=1 and oDISP_TAG=0 (wrapped) in the next cycle.
- Flush mid-operation:
  - Stimulus: 3 entries allocated, 2 done; iFLUSH asserted together with a LOGIC completion.
  - Required: oFLAG_WE=0 in that cycle; next cycle oCOUNT=0 and oDISP_TAG=0.
- Hold:
  - Stimulus: iCTRL_HOLD high; SHIFT completes head tag with 5'h1F.
  - Required: no write during hold; oFLAG_WE=1 with data 5'h1F in the first cycle after hold drops.
- Parallel and conflicting completions:
  - Stimulus A: SHIFT tag 0 = 5'h01 and LOGIC tag 1 = 5'h1E in the same cycle. Required: commits in consecutive cycles with data 5'h01 then 5'h1E.
  - Stimulus B: ADDER and MUL both name tag 0 in the same cycle. Required: the adder's value is committed.
